lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store initiator that sits between the execute stage and the byte-addressed, big-endian data memory. The memory has a combinational word read and a synchronous full-word write. The block accepts one load or store request at a time and drives the memory's address, write-enable and write-data inputs. Byte and halfword stores are done as read-modify-write, because the memory only writes whole words. Load results are extracted and sign- or zero-extended before being returned to the pipeline.

Parameters:
DATA_W, 32, data word width; fixed at 32.
ADDR_W, 32, width of request and memory address. The memory itself decodes only its low 14 bits.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  block idle and able to accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; byte/half taken from LSBs
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load result (0 for stores)
resp_fault  out  1  misalignment fault (see Optional Feature)
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; mem_we=0; mem_addr=0; mem_wdata=0. All latched request registers are cleared to 0.
- Memory byte order: a read at address A returns bytes A..A+3 with A in bits [31:24].
  - Byte access uses bits [31:24].
  - Halfword access uses bits [31:16].
  - Word access uses all 32 bits.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch we/size/unsigned/addr/wdata and move to ACCESS.
- ACCESS: mem_addr = latched address.
  - Load: register the extracted and extended value into resp_rdata; move to RESP.
  - Word store: mem_we=1, mem_wdata = latched wdata; move to RESP.
  - Byte store: register the merge word {wdata[7:0], mem_rdata[23:0]}; move to WRITE.
  - Half store: register the merge word {wdata[15:0], mem_rdata[15:0]}; move to WRITE.
- WRITE: mem_addr = latched address; mem_we=1; mem_wdata = merge register; move to RESP.
- RESP: resp_valid=1 for exactly one cycle; move to IDLE.
- The response path has no backpressure.
- req_ready is 0 in every state except IDLE.
- Latency, counted from the accept edge to the edge that ends the resp_valid cycle:
  - Loads and word stores: 2 cycles.
  - Sub-word stores: 3 cycles.
- mem_we is high for exactly one cycle per store and never during loads.
- mem_we and mem_wdata are decoded from the current state and registers. mem_addr is 0 while in IDLE.
- Extension rules:
  - LB: {{24{b[7]}}, b}; LBU: zero-extend.
  - LH: {{16{h[15]}}, h}; LHU: zero-extend.
  - Word: ignores req_unsigned.
- Address wrap: the full address is passed through unchanged. Truncation and end-of-array wrap are the memory's responsibility.
- Reset mid-operation:
  - The FSM returns to IDLE and the request is dropped with no response.
  - If rst is sampled on the same edge at which mem_we=1, the memory write still occurs, because the memory has no reset.
  - A sub-word store reset while in ACCESS leaves memory unchanged.
- A request offered in the same cycle as rst=1 is not accepted.

Optional Feature:
Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned access is a halfword with addr[0]=1, or a word (size 10 or 11) with addr[1:0]!=00.
  - On a misaligned access, ACCESS performs no memory read and no write, mem_we stays 0, and the FSM moves directly to RESP.
  - In RESP: resp_fault=1 and resp_rdata=0. resp_fault is registered and is 0 in every other cycle.
- Not defined: resp_fault is tied to 0, and unaligned accesses proceed as ordinary byte-addressed accesses.

Test Plan:
1. Preload bytes 0x10..0x13 = 80,12,34,56. Issue LB 0x10 signed -> resp_rdata=0xFFFFFF80, resp_valid high exactly 2 cycles after the accept edge, mem_we never asserted.
2. Same preload. LBU 0x10 -> 0x00000080; LH 0x10 -> 0xFFFF8012; LHU 0x10 -> 0x00008012; LW 0x10 -> 0x80123456.
3. Same preload. SB 0x11 with wdata=0xAABBCCDD -> one read then one mem_we pulse at 0x11; a following LW 0x10 returns 0x80DD3456; resp_valid occurs 3 cycles after accept.
4. SW 0x20 with 0xDEADBEEF -> mem_we for exactly one cycle in ACCESS with mem_wdata=0xDEADBEEF; a following LW 0x20 returns 0xDEADBEEF. SH 0x20 with 0x00001234 -> a following LW 0x20 returns 0x1234BEEF.
5. Hold req_valid=1 continuously with back-to-back LW requests -> req_ready=1 only in IDLE cycles; one request accepted every 3 cycles; no request lost or duplicated.
6. Reset handling:
   - Assert rst during ACCESS of SH 0x30 -> memory at 0x30 unchanged, no resp_valid, req_ready=1 in the cycle after the reset edge.
   - With LSU_MISALIGN_CHECK_EN, LW 0x31 -> resp_fault=1, resp_rdata=0, no mem_we.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a big-endian, word-write data memory; sub-word stores use read-modify-write.
// Optional misalignment faulting is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic              fault_q;
  logic              misaligned;
  logic              word_store;
  logic [DATA_W-1:0] load_val;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = (size_q == 2'b01 && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The addressed byte always lands in the MSBs of the read word.
  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, mem_rdata[31:24]} : {{24{mem_rdata[31]}}, mem_rdata[31:24]};
      2'b01:   load_val = uns_q ? {16'b0, mem_rdata[31:16]} : {{16{mem_rdata[31]}}, mem_rdata[31:16]};
      default: load_val = mem_rdata;
    endcase
  end

  assign word_store = (state == ACCESS) && we_q && size_q[1] && !misaligned;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_fault = fault_q;
  assign mem_addr   = (state == IDLE) ? '0 : addr_q;
  assign mem_we     = word_store || (state == WRITE);
  assign mem_wdata  = (state == WRITE) ? merge_q : (word_store ? wdata_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      fault_q    <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          fault_q <= 1'b0;
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (misaligned) begin
            fault_q    <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else if (!we_q) begin
            resp_rdata <= load_val;
            state      <= RESP;
          end else if (size_q[1]) begin
            state <= RESP;
          end else begin
            merge_q <= size_q[0] ? {wdata_q[15:0], mem_rdata[15:0]}
                                 : {wdata_q[7:0], mem_rdata[23:0]};
            state   <= WRITE;
          end
        end
        WRITE: state <= RESP;
        default: begin
          fault_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-array memory, vector table, hand sequences and a randomized run
// against a byte-level reference model.
module tb_lsu_mem_ctrl;
  logic        clk = 0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory under the DUT, with a backdoor poke port used only while the DUT is held in reset.
  logic [7:0]  dmem [0:16383];
  logic        pk_we = 0;
  logic [13:0] pk_a = 0;
  logic [7:0]  pk_d = 0;

  function automatic logic [31:0] dmem_word(input logic [13:0] a);
    return {dmem[a], dmem[a + 14'd1], dmem[a + 14'd2], dmem[a + 14'd3]};
  endfunction

  always_comb mem_rdata = dmem_word(mem_addr[13:0]);

  always @(posedge clk) begin
    if (pk_we) dmem[pk_a] <= pk_d;
    if (mem_we) begin
      dmem[mem_addr[13:0]]         <= mem_wdata[31:24];
      dmem[mem_addr[13:0] + 14'd1] <= mem_wdata[23:16];
      dmem[mem_addr[13:0] + 14'd2] <= mem_wdata[15:8];
      dmem[mem_addr[13:0] + 14'd3] <= mem_wdata[7:0];
    end
  end

  // Reference model: plain byte array updated by access semantics.
  logic [7:0] ref_mem [0:16383];
  int vecs = 0;
  int errs = 0;

  function automatic logic [31:0] ref_word(input logic [13:0] a);
    return {ref_mem[a], ref_mem[a + 14'd1], ref_mem[a + 14'd2], ref_mem[a + 14'd3]};
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] er, output int el, output int ew,
                       output logic ef);
    logic [31:0] w;
    logic [13:0] i;
    i = a[13:0];
    ef = misal(sz, a); er = 0; el = 2; ew = 0;
    if (ef) return;
    if (!we) begin
      w = ref_word(i);
      if (sz == 2'd0)      er = uns ? {24'b0, w[31:24]} : {{24{w[31]}}, w[31:24]};
      else if (sz == 2'd1) er = uns ? {16'b0, w[31:16]} : {{16{w[31]}}, w[31:16]};
      else                 er = w;
    end else begin
      ew = 1;
      if (sz == 2'd0) begin
        el = 3; ref_mem[i] = wd[7:0];
      end else if (sz == 2'd1) begin
        el = 3; ref_mem[i] = wd[15:8]; ref_mem[i + 14'd1] = wd[7:0];
      end else begin
        ref_mem[i] = wd[31:24]; ref_mem[i + 14'd1] = wd[23:16];
        ref_mem[i + 14'd2] = wd[15:8]; ref_mem[i + 14'd3] = wd[7:0];
      end
    end
  endtask

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // One request; returns response data, latency in cycles after the accept edge, write pulses, fault.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output int wecnt, output logic flt);
    int guard;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 0; wecnt = 0; rd = 0; flt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_we) begin
        wecnt++;
        check("we_addr", mem_addr, a);
        if (we && sz[1]) check("word_wdata", mem_wdata, wd);
      end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; flt = resp_fault;
        break;
      end
    end
    @(negedge clk);
    check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_op(input string n, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic use_tab,
                        input logic [31:0] t_rd, input int t_lat);
    logic [31:0] er, rd;
    int el, ew, lat, wecnt;
    logic ef, flt;
    model(we, sz, uns, a, wd, er, el, ew, ef);
    do_req(we, sz, uns, a, wd, rd, lat, wecnt, flt);
    check({n, "_rdata"}, rd, use_tab ? t_rd : er);
    check({n, "_lat"}, 32'(lat), use_tab ? 32'(t_lat) : 32'(el));
    check({n, "_we"}, 32'(wecnt), 32'(ew));
    check({n, "_fault"}, {31'b0, flt}, {31'b0, ef});
    if (we) check({n, "_mem"}, dmem_word(a[13:0]), ref_word(a[13:0]));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tab [13];

  initial begin
    logic [31:0] w30;
    int acc, rsp, bad;

    tab[0]  = '{0, 2'd0, 0, 32'h10, 32'h0,        32'hFFFFFF80, 2};
    tab[1]  = '{0, 2'd0, 1, 32'h10, 32'h0,        32'h00000080, 2};
    tab[2]  = '{0, 2'd1, 0, 32'h10, 32'h0,        32'hFFFF8012, 2};
    tab[3]  = '{0, 2'd1, 1, 32'h10, 32'h0,        32'h00008012, 2};
    tab[4]  = '{0, 2'd2, 0, 32'h10, 32'h0,        32'h80123456, 2};
    tab[5]  = '{1, 2'd0, 0, 32'h11, 32'hAABBCCDD, 32'h0,        3};
    tab[6]  = '{0, 2'd2, 0, 32'h10, 32'h0,        32'h80DD3456, 2};
    tab[7]  = '{1, 2'd2, 0, 32'h20, 32'hDEADBEEF, 32'h0,        2};
    tab[8]  = '{0, 2'd2, 0, 32'h20, 32'h0,        32'hDEADBEEF, 2};
    tab[9]  = '{1, 2'd1, 0, 32'h20, 32'h00001234, 32'h0,        3};
    tab[10] = '{0, 2'd2, 0, 32'h20, 32'h0,        32'h1234BEEF, 2};
    tab[11] = '{0, 2'd3, 1, 32'h20, 32'h0,        32'h1234BEEF, 2};
    tab[12] = '{0, 2'd2, 1, 32'h10, 32'h0,        32'h80DD3456, 2};

    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pk_we = 1; pk_a = 14'(i);
      case (i)
        16'h10:  pk_d = 8'h80;
        16'h11:  pk_d = 8'h12;
        16'h12:  pk_d = 8'h34;
        16'h13:  pk_d = 8'h56;
        default: pk_d = 8'h00;
      endcase
      ref_mem[i] = pk_d;
    end
    @(negedge clk);
    pk_we = 0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", {31'b0, resp_fault}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 0;

    foreach (tab[i])
      run_op($sformatf("tab%0d", i), tab[i].we, tab[i].sz, tab[i].uns, tab[i].addr, tab[i].wdata,
             1'b1, tab[i].exp_rd, tab[i].exp_lat);

    // Back-to-back loads with req_valid held high: one accept and one response every 3 cycles.
    acc = 0; rsp = 0; bad = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h10;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (req_ready !== (k % 3 == 0)) bad++;
      if (req_ready) acc++;
      if (resp_valid) begin
        rsp++;
        if (resp_rdata !== ref_word(14'h10)) bad++;
      end
    end
    req_valid = 0;
    check("b2b_accepts", 32'(acc), 32'd10);
    check("b2b_resps", 32'(rsp), 32'd10);
    check("b2b_pattern", 32'(bad), 32'd0);
    @(negedge clk);

    // Reset while a halfword store is in ACCESS: request dropped, memory untouched.
    w30 = ref_word(14'h30);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd1; req_addr = 32'h30; req_wdata = 32'h0000FFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    rsp = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) rsp++;
      @(negedge clk);
    end
    check("rst_mid_noresp", 32'(rsp), 32'd0);
    check("rst_mid_mem", dmem_word(14'h30), w30);

    // A request offered alongside reset must not be taken.
    rst = 1; req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    rst = 0; req_valid = 0;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    rsp = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) rsp++;
      @(negedge clk);
    end
    check("rst_req_noresp", 32'(rsp), 32'd0);

    // Unaligned accesses: faulted with the check enabled, plain byte-addressed otherwise.
    run_op("lw31", 0, 2'd2, 0, 32'h31, 32'h0, 1'b0, 32'h0, 0);
    run_op("lh21", 0, 2'd1, 1, 32'h21, 32'h0, 1'b0, 32'h0, 0);
    run_op("sw22", 1, 2'd2, 0, 32'h22, 32'hCAFEF00D, 1'b0, 32'h0, 0);
    run_op("sh13", 1, 2'd1, 0, 32'h13, 32'h00005A5A, 1'b0, 32'h0, 0);

    for (int n = 0; n < 150; n++)
      run_op("rnd", 1'($urandom), 2'($urandom), 1'($urandom), 32'h40 + $urandom_range(0, 15),
             $urandom, 1'b0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
